// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// mem_port_arbiter_if: I-fetch, load/store, memory and perf signals of the arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if;
  // fetch side
  logic        i_req;
  logic [29:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  // load/store side
  logic        d_req;
  logic        d_rw;
  logic [29:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  // memory macro side
  logic        m_req;
  logic        m_rw;
  logic [29:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  // stall statistics
  logic [15:0] perf_i_stall;
  logic [15:0] perf_d_stall;

  // environment view: core pipeline plus memory macro
  modport master (
    output i_req, i_addr, d_req, d_rw, d_addr, d_wdata, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  m_req, m_rw, m_addr, m_wdata, perf_i_stall, perf_d_stall
  );

  // arbiter view
  modport slave (
    input  i_req, i_addr, d_req, d_rw, d_addr, d_wdata, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output m_req, m_rw, m_addr, m_wdata, perf_i_stall, perf_d_stall
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter: shares one single-ported memory between fetch (I) and
// load/store (D); define ARB_PERF_CNT_EN to build the stall counters. Rev 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int LAT      = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = (MAX_WAIT < 1) ? '0 : WCW'(MAX_WAIT - 1);
  localparam logic [WCW-1:0] WAIT_MAX  = WCW'(MAX_WAIT);

  typedef enum logic [0:0] {
    D_PRIO = 1'b0,
    I_PRIO = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [WCW-1:0] wait_cnt;
  logic [WCW-1:0] wait_nxt;
  logic           i_gnt;
  logic           d_gnt;

  logic           m_side;   // 1 = command belongs to D
  logic [LAT-1:0] tag_v;
  logic [LAT-1:0] tag_s;
  logic           ret_i;
  logic           ret_d;
  logic [31:0]    i_rdata_q;
  logic [31:0]    d_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= D_PRIO;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Grants are masked while reset is asserted so every output reads 0 at once.
  always_comb begin
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    state_nxt = state;
    wait_nxt  = wait_cnt;

    if (!rst) begin
      if (state == I_PRIO) begin
        if (bus.i_req)      i_gnt = 1'b1;
        else if (bus.d_req) d_gnt = 1'b1;
      end else begin
        if (bus.d_req)      d_gnt = 1'b1;
        else if (bus.i_req) i_gnt = 1'b1;
      end
    end

    case (state)
      D_PRIO: begin
        if ((MAX_WAIT != 0) && (wait_cnt == WAIT_LAST) && bus.i_req && d_gnt)
          state_nxt = I_PRIO;
      end
      I_PRIO: begin
        if (i_gnt || !bus.i_req)
          state_nxt = D_PRIO;
      end
      default: state_nxt = D_PRIO;
    endcase

    if (i_gnt || !bus.i_req)
      wait_nxt = '0;
    else if (d_gnt && (wait_cnt != WAIT_MAX))
      wait_nxt = wait_cnt + 1'b1;
  end

  assign bus.i_gnt = i_gnt;
  assign bus.d_gnt = d_gnt;

  // Registered memory command; fields only move when something is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.m_req   <= 1'b0;
      bus.m_rw    <= 1'b0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
      m_side      <= 1'b0;
    end else begin
      bus.m_req <= i_gnt | d_gnt;
      if (d_gnt) begin
        bus.m_rw   <= bus.d_rw;
        bus.m_addr <= bus.d_addr;
        m_side     <= 1'b1;
        if (bus.d_rw)
          bus.m_wdata <= bus.d_wdata;
      end else if (i_gnt) begin
        bus.m_rw   <= 1'b0;
        bus.m_addr <= bus.i_addr;
        m_side     <= 1'b0;
      end
    end
  end

  // Tag pipeline fed from the issued command: entry LAT-1 lines up with M_RDATA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v <= '0;
      tag_s <= '0;
    end else begin
      for (int k = LAT - 1; k > 0; k--) begin
        tag_v[k] <= tag_v[k-1];
        tag_s[k] <= tag_s[k-1];
      end
      tag_v[0] <= bus.m_req & ~bus.m_rw;
      tag_s[0] <= m_side;
    end
  end

  assign ret_i = tag_v[LAT-1] & ~tag_s[LAT-1];
  assign ret_d = tag_v[LAT-1] &  tag_s[LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (ret_i) i_rdata_q <= bus.m_rdata;
      if (ret_d) d_rdata_q <= bus.m_rdata;
    end
  end

  assign bus.i_rvalid = ret_i;
  assign bus.d_rvalid = ret_d;
  assign bus.i_rdata  = ret_i ? bus.m_rdata : i_rdata_q;
  assign bus.d_rdata  = ret_d ? bus.m_rdata : d_rdata_q;

`ifdef ARB_PERF_CNT_EN
  logic [15:0] perf_i_q;
  logic [15:0] perf_d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_i_q <= '0;
      perf_d_q <= '0;
    end else begin
      if (bus.i_req && !i_gnt && (perf_i_q != 16'hFFFF)) perf_i_q <= perf_i_q + 16'd1;
      if (bus.d_req && !d_gnt && (perf_d_q != 16'hFFFF)) perf_d_q <= perf_d_q + 16'd1;
    end
  end

  assign bus.perf_i_stall = perf_i_q;
  assign bus.perf_d_stall = perf_d_q;
`else
  assign bus.perf_i_stall = 16'h0000;
  assign bus.perf_d_stall = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter: directed checks on a LAT=1 and a LAT=3 arbiter. Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

`ifdef ARB_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  mem_port_arbiter_if bus1 ();
  mem_port_arbiter_if bus3 ();

  mem_port_arbiter #(.LAT(1), .MAX_WAIT(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mem_port_arbiter #(.LAT(3), .MAX_WAIT(4)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus1.i_req = 1'b1; bus1.d_req = 1'b1;
    bus3.i_req = 1'b1; bus3.d_req = 1'b1;
    tick(); tick();
    n_checks++;
    if ({bus1.i_gnt, bus1.d_gnt, bus3.i_gnt, bus3.d_gnt} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_gnt: got %b expected 0000", {bus1.i_gnt, bus1.d_gnt, bus3.i_gnt, bus3.d_gnt});
    end
    n_checks++;
    if ({bus1.m_req, bus1.m_rw, bus1.m_addr, bus1.m_wdata, bus1.i_rvalid, bus1.d_rvalid} !== 66'd0) begin
      n_fail++;
      $display("FAIL reset_mem: got m_req=%b m_addr=%h expected all zero", bus1.m_req, bus1.m_addr);
    end
    n_checks++;
    if ({bus1.i_rdata, bus1.d_rdata, bus1.perf_i_stall, bus1.perf_d_stall} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_data: got i_rdata=%h perf_i=%0d expected 0", bus1.i_rdata, bus1.perf_i_stall);
    end
    bus1.i_req = 1'b0; bus1.d_req = 1'b0;
    bus3.i_req = 1'b0; bus3.d_req = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    tick();
    bus1.i_req = 1'b1; bus1.i_addr = 30'h10;
    #1;
    n_checks++;
    if ({bus1.i_gnt, bus1.d_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL single_gnt: got %b expected 10", {bus1.i_gnt, bus1.d_gnt});
    end
    tick();
    bus1.i_req = 1'b0;
    #1;
    n_checks++;
    if ({bus1.m_req, bus1.m_rw, bus1.m_addr} !== {1'b1, 1'b0, 30'h10}) begin
      n_fail++; $display("FAIL single_cmd: got req=%b rw=%b addr=%h expected 1 0 10", bus1.m_req, bus1.m_rw, bus1.m_addr);
    end
    tick();
    bus1.m_rdata = 32'hDEADBEEF;
    #1;
    n_checks++;
    if ({bus1.i_rvalid, bus1.i_rdata, bus1.d_rvalid, bus1.m_req} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL single_ret: got iv=%b id=%h dv=%b mreq=%b expected 1 deadbeef 0 0", bus1.i_rvalid, bus1.i_rdata, bus1.d_rvalid, bus1.m_req);
    end
    tick();
    bus1.m_rdata = 32'h0;
    #1;
    n_checks++;
    if ({bus1.i_rvalid, bus1.i_rdata} !== {1'b0, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL single_hold: got iv=%b id=%h expected 0 deadbeef", bus1.i_rvalid, bus1.i_rdata);
    end
  endtask

  task automatic test_simultaneous();
    tick();
    bus1.i_req = 1'b1; bus1.i_addr = 30'h44;
    bus1.d_req = 1'b1; bus1.d_rw = 1'b0; bus1.d_addr = 30'h20;
    #1;
    n_checks++;
    if ({bus1.i_gnt, bus1.d_gnt} !== 2'b01) begin
      n_fail++; $display("FAIL simul_first: got %b expected 01", {bus1.i_gnt, bus1.d_gnt});
    end
    tick();
    bus1.d_req = 1'b0;
    #1;
    n_checks++;
    if ({bus1.i_gnt, bus1.d_gnt, bus1.m_req, bus1.m_addr} !== {2'b10, 1'b1, 30'h20}) begin
      n_fail++; $display("FAIL simul_second: got gnt=%b mreq=%b maddr=%h expected 10 1 20", {bus1.i_gnt, bus1.d_gnt}, bus1.m_req, bus1.m_addr);
    end
    tick();
    bus1.i_req = 1'b0;
    bus1.m_rdata = 32'h0D0D0D0D;
    #1;
    n_checks++;
    if ({bus1.d_rvalid, bus1.d_rdata, bus1.i_rvalid, bus1.m_req, bus1.m_addr} !== {1'b1, 32'h0D0D0D0D, 1'b0, 1'b1, 30'h44}) begin
      n_fail++; $display("FAIL simul_ret_d: got dv=%b dd=%h iv=%b maddr=%h expected 1 0d0d0d0d 0 44", bus1.d_rvalid, bus1.d_rdata, bus1.i_rvalid, bus1.m_addr);
    end
    tick();
    bus1.m_rdata = 32'h11112222;
    #1;
    n_checks++;
    if ({bus1.i_rvalid, bus1.i_rdata, bus1.d_rvalid, bus1.d_rdata} !== {1'b1, 32'h11112222, 1'b0, 32'h0D0D0D0D}) begin
      n_fail++; $display("FAIL simul_ret_i: got iv=%b id=%h dv=%b dd=%h expected 1 11112222 0 0d0d0d0d", bus1.i_rvalid, bus1.i_rdata, bus1.d_rvalid, bus1.d_rdata);
    end
    tick();
    #1;
    n_checks++;
    if ({bus1.i_rvalid, bus1.d_rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL simul_idle: got %b expected 00", {bus1.i_rvalid, bus1.d_rvalid});
    end
  endtask

  task automatic test_max_wait();
    logic [1:0]  exp_gnt;
    logic [29:0] exp_addr;
    tick();
    rst = 1'b1; #1; rst = 1'b0;
    bus1.d_req = 1'b1; bus1.d_rw = 1'b0; bus1.d_addr = 30'h100;
    bus1.i_req = 1'b1; bus1.i_addr = 30'h200;
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_gnt = (k == 4) ? 2'b10 : 2'b01;
      n_checks++;
      if ({bus1.i_gnt, bus1.d_gnt} !== exp_gnt) begin
        n_fail++; $display("FAIL maxwait_gnt[%0d]: got %b expected %b", k, {bus1.i_gnt, bus1.d_gnt}, exp_gnt);
      end
      if (k > 0) begin
        exp_addr = (k == 5) ? 30'h200 : 30'h100;
        n_checks++;
        if ({bus1.m_req, bus1.m_addr} !== {1'b1, exp_addr}) begin
          n_fail++; $display("FAIL maxwait_cmd[%0d]: got req=%b addr=%h expected 1 %h", k, bus1.m_req, bus1.m_addr, exp_addr);
        end
      end
      tick();
      if (k == 4) bus1.i_req = 1'b0;
      if (k == 5) bus1.d_req = 1'b0;
    end
    #1;
    n_checks++;
    if ({bus1.perf_i_stall, bus1.perf_d_stall} !== {(PERF_ON ? 16'd4 : 16'd0), (PERF_ON ? 16'd1 : 16'd0)}) begin
      n_fail++; $display("FAIL maxwait_perf: got i=%0d d=%0d expected %0d %0d", bus1.perf_i_stall, bus1.perf_d_stall, PERF_ON ? 4 : 0, PERF_ON ? 1 : 0);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_write();
    tick();
    bus1.d_req = 1'b1; bus1.d_rw = 1'b1; bus1.d_addr = 30'h8; bus1.d_wdata = 32'h12345678;
    #1;
    n_checks++;
    if ({bus1.i_gnt, bus1.d_gnt} !== 2'b01) begin
      n_fail++; $display("FAIL write_gnt: got %b expected 01", {bus1.i_gnt, bus1.d_gnt});
    end
    tick();
    bus1.d_req = 1'b0; bus1.d_rw = 1'b0; bus1.d_wdata = 32'h0;
    #1;
    n_checks++;
    if ({bus1.m_req, bus1.m_rw, bus1.m_addr, bus1.m_wdata} !== {1'b1, 1'b1, 30'h8, 32'h12345678}) begin
      n_fail++; $display("FAIL write_cmd: got req=%b rw=%b addr=%h wd=%h expected 1 1 8 12345678", bus1.m_req, bus1.m_rw, bus1.m_addr, bus1.m_wdata);
    end
    tick();
    bus1.m_rdata = 32'h55555555;
    #1;
    n_checks++;
    if ({bus1.i_rvalid, bus1.d_rvalid, bus1.m_req, bus1.m_rw, bus1.m_wdata} !== {3'b000, 1'b1, 32'h12345678}) begin
      n_fail++; $display("FAIL write_noret: got iv=%b dv=%b mreq=%b rw=%b wd=%h expected 0 0 0 1 12345678", bus1.i_rvalid, bus1.d_rvalid, bus1.m_req, bus1.m_rw, bus1.m_wdata);
    end
  endtask

  task automatic test_lat3_read();
    tick();
    bus3.i_req = 1'b1; bus3.i_addr = 30'h3C;
    #1;
    n_checks++;
    if ({bus3.i_gnt, bus3.d_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL lat3_gnt: got %b expected 10", {bus3.i_gnt, bus3.d_gnt});
    end
    tick();
    bus3.i_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      n_checks++;
      if ({bus3.i_rvalid, bus3.d_rvalid} !== 2'b00) begin
        n_fail++; $display("FAIL lat3_early[t+%0d]: got %b expected 00", k, {bus3.i_rvalid, bus3.d_rvalid});
      end
      tick();
    end
    bus3.m_rdata = 32'hCAFEF00D;
    #1;
    n_checks++;
    if ({bus3.i_rvalid, bus3.i_rdata, bus3.d_rvalid} !== {1'b1, 32'hCAFEF00D, 1'b0}) begin
      n_fail++; $display("FAIL lat3_ret: got iv=%b id=%h dv=%b expected 1 cafef00d 0", bus3.i_rvalid, bus3.i_rdata, bus3.d_rvalid);
    end
  endtask

  task automatic test_reset_inflight();
    tick();
    bus3.m_rdata = 32'hBAD0BAD0;
    bus3.i_req = 1'b1; bus3.i_addr = 30'h30;
    #1;
    n_checks++;
    if (bus3.i_gnt !== 1'b1) begin
      n_fail++; $display("FAIL rstfl_gnt: got %b expected 1", bus3.i_gnt);
    end
    tick();
    bus3.i_req = 1'b0;
    bus3.d_req = 1'b1; bus3.d_rw = 1'b0; bus3.d_addr = 30'h34;
    #1;
    n_checks++;
    if ({bus3.d_gnt, bus3.m_req, bus3.m_addr} !== {1'b1, 1'b1, 30'h30}) begin
      n_fail++; $display("FAIL rstfl_issue: got dg=%b mreq=%b maddr=%h expected 1 1 30", bus3.d_gnt, bus3.m_req, bus3.m_addr);
    end
    tick();
    bus3.d_req = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus3.m_req, bus3.m_rw, bus3.m_addr, bus3.i_rvalid, bus3.d_rvalid, bus3.i_rdata, bus3.d_rdata} !== 96'd0) begin
      n_fail++; $display("FAIL rstfl_async: got mreq=%b maddr=%h id=%h expected all zero", bus3.m_req, bus3.m_addr, bus3.i_rdata);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if ({bus3.i_rvalid, bus3.d_rvalid, bus3.m_req, bus3.i_rdata} !== 35'd0) begin
        n_fail++; $display("FAIL rstfl_after[%0d]: got iv=%b dv=%b mreq=%b id=%h expected 0 0 0 0", k, bus3.i_rvalid, bus3.d_rvalid, bus3.m_req, bus3.i_rdata);
      end
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus1.i_req = 1'b0; bus1.i_addr = '0; bus1.d_req = 1'b0; bus1.d_rw = 1'b0;
    bus1.d_addr = '0; bus1.d_wdata = '0; bus1.m_rdata = '0;
    bus3.i_req = 1'b0; bus3.i_addr = '0; bus3.d_req = 1'b0; bus3.d_rw = 1'b0;
    bus3.d_addr = '0; bus3.d_wdata = '0; bus3.m_rdata = '0;

    test_reset();
    test_single_read();
    test_simultaneous();
    test_max_wait();
    test_write();
    test_lat3_read();
    test_reset_inflight();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
